// File: rtl/alu_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_pipe
// Purpose  : Two-stage execute pipeline around an external combinational
//            32-bit ALU. An execute register (E) drives the ALU operands; the
//            ALU result and flags are captured into a 2-entry output FIFO that
//            drains over a valid/ready handshake. Also maintains sticky
//            carry/overflow flags and a saturating completed-operation count.
// Ports    :
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               upstream handshake
//   in_a, in_b, in_op, in_tag       transaction payload
//   alu_a, alu_b, alu_op            operands to the external ALU (from E)
//   alu_result, alu_carryout,
//   alu_overflow, alu_zero          results back from the external ALU
//   out_valid/out_ready             downstream handshake
//   out_result, out_carry, out_ovf,
//   out_zero, out_illegal, out_tag  head entry of the output buffer
//   flag_clr                        clear sticky flags (a same-cycle set wins)
//   sticky_carry, sticky_ovf        OR of pushed carry/overflow since clear
//   op_count                        entries popped since reset (saturating)
// Revision : 1.0  initial release
// ============================================================================
module alu_exec_pipe #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [3:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    input  logic             flag_clr,
    output logic             sticky_carry,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [3:0] c_MAX_LEGAL_OP = 4'd8;
    localparam logic [3:0] c_OP_SUB       = 4'd1;

    // Execute stage
    logic             r_e_valid;
    logic [31:0]      r_e_a;
    logic [31:0]      r_e_b;
    logic [3:0]       r_e_op;
    logic [TAG_W-1:0] r_e_tag;

    // Output buffer storage, head pointer and occupancy (0..2)
    logic [31:0]      r_buf_result  [2];
    logic             r_buf_carry   [2];
    logic             r_buf_ovf     [2];
    logic             r_buf_zero    [2];
    logic             r_buf_illegal [2];
    logic [TAG_W-1:0] r_buf_tag     [2];
    logic             r_head;
    logic [1:0]       r_count;

    logic             w_pop;
    logic             w_push;
    logic             w_load;
    logic             w_wr_idx;
    logic             w_illegal;
    logic             w_arith;
    logic [31:0]      w_ent_result;
    logic             w_ent_carry;
    logic             w_ent_ovf;
    logic             w_ent_zero;

    // Handshake decisions. A full buffer can still accept a push when the
    // head is popped in the same cycle, which is the only reason in_ready
    // depends combinationally on out_ready.
    assign w_pop    = out_valid && out_ready;
    assign w_push   = r_e_valid && (!r_count[1] || w_pop);
    assign in_ready = !r_e_valid || w_push;
    assign w_load   = in_valid && in_ready;

    // Tail slot is head+count modulo 2; with count=2 and a pop this is the
    // slot being vacated by the head, so the write lands there.
    assign w_wr_idx = r_head ^ r_count[0];

    // Entry formation from the ALU response
    assign w_illegal    = (r_e_op > c_MAX_LEGAL_OP);
    assign w_arith      = (r_e_op <= c_OP_SUB);
    assign w_ent_result = w_illegal ? 32'd0 : alu_result;
    assign w_ent_zero   = w_illegal ? 1'b1  : alu_zero;
    assign w_ent_carry  = w_arith && alu_carryout;
    assign w_ent_ovf    = w_arith && alu_overflow;

    assign alu_a  = r_e_a;
    assign alu_b  = r_e_b;
    assign alu_op = r_e_op;

    assign out_valid   = (r_count != 2'd0);
    assign out_result  = r_buf_result[r_head];
    assign out_carry   = r_buf_carry[r_head];
    assign out_ovf     = r_buf_ovf[r_head];
    assign out_zero    = r_buf_zero[r_head];
    assign out_illegal = r_buf_illegal[r_head];
    assign out_tag     = r_buf_tag[r_head];

    // Execute register: operand fields hold when E empties so the ALU inputs
    // stay quiet between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_valid <= 1'b0;
            r_e_a     <= 32'd0;
            r_e_b     <= 32'd0;
            r_e_op    <= 4'd0;
            r_e_tag   <= '0;
        end else if (w_load) begin
            r_e_valid <= 1'b1;
            r_e_a     <= in_a;
            r_e_b     <= in_b;
            r_e_op    <= in_op;
            r_e_tag   <= in_tag;
        end else if (w_push) begin
            r_e_valid <= 1'b0;
        end
    end

    // Output buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_result[i]  <= 32'd0;
                r_buf_carry[i]   <= 1'b0;
                r_buf_ovf[i]     <= 1'b0;
                r_buf_zero[i]    <= 1'b0;
                r_buf_illegal[i] <= 1'b0;
                r_buf_tag[i]     <= '0;
            end
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf_result[w_wr_idx]  <= w_ent_result;
                r_buf_carry[w_wr_idx]   <= w_ent_carry;
                r_buf_ovf[w_wr_idx]     <= w_ent_ovf;
                r_buf_zero[w_wr_idx]    <= w_ent_zero;
                r_buf_illegal[w_wr_idx] <= w_illegal;
                r_buf_tag[w_wr_idx]     <= r_e_tag;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    // Sticky flags (set beats clear) and saturating pop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_carry <= 1'b0;
            sticky_ovf   <= 1'b0;
            op_count     <= '0;
        end else begin
            sticky_carry <= (sticky_carry && !flag_clr) || (w_push && w_ent_carry);
            sticky_ovf   <= (sticky_ovf   && !flag_clr) || (w_push && w_ent_ovf);
            if (w_pop && (op_count != {CNT_W{1'b1}})) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_pipe
// Purpose  : Self-checking bench for alu_exec_pipe. Provides a combinational
//            ALU model (which drives junk flags where the pipeline must force
//            them), a transaction-level reference queue, and directed plus
//            randomized stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_pipe;

    localparam int TAG_W = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [3:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_op;
    logic [31:0]      alu_result;
    logic             alu_carryout;
    logic             alu_overflow;
    logic             alu_zero;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_carry;
    logic             out_ovf;
    logic             out_zero;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
    logic             flag_clr;
    logic             sticky_carry;
    logic             sticky_ovf;
    logic [CNT_W-1:0] op_count;

    alu_exec_pipe #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carryout(alu_carryout),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_illegal(out_illegal), .out_tag(out_tag),
        .flag_clr(flag_clr), .sticky_carry(sticky_carry),
        .sticky_ovf(sticky_ovf), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain-arithmetic ALU: returns {carry, overflow, result}
    function automatic logic [33:0] ref_core(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic c;
        logic o;
        s = 33'd0; r = 32'd0; c = 1'b0; o = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                o = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            4'd4: r = a | b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = {31'd0, ($signed(a) < $signed(b))};
            4'd8: r = {31'd0, (a < b)};
            default: r = 32'd0;
        endcase
        return {c, o, r};
    endfunction

    // External ALU: flags not meaningful for an opcode are driven with junk
    // so the pipeline's forcing rules are actually exercised.
    logic [33:0] env_x;
    always_comb begin
        env_x        = ref_core(alu_a, alu_b, alu_op);
        alu_result   = env_x[31:0];
        alu_zero     = (env_x[31:0] == 32'd0);
        alu_carryout = env_x[33];
        alu_overflow = env_x[32];
        if (alu_op > 4'd1) begin
            alu_carryout = ^alu_a;
            alu_overflow = alu_b[0];
        end
        if (alu_op > 4'd8) begin
            alu_result = alu_a ^ alu_b;
            alu_zero   = 1'b0;
        end
    end

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
        logic [31:0]      r;
        logic             c;
        logic             o;
        logic             z;
        logic             il;
    } ent_t;

    function automatic ent_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] op, input logic [TAG_W-1:0] tag);
        ent_t e;
        logic [33:0] x;
        x = ref_core(a, b, op);
        e.a = a; e.b = b; e.op = op; e.tag = tag;
        if (op > 4'd8) begin
            e.r = 32'd0; e.z = 1'b1; e.c = 1'b0; e.o = 1'b0; e.il = 1'b1;
        end else begin
            e.r  = x[31:0];
            e.z  = (x[31:0] == 32'd0);
            e.c  = (op <= 4'd1) ? x[33] : 1'b0;
            e.o  = (op <= 4'd1) ? x[32] : 1'b0;
            e.il = 1'b0;
        end
        return e;
    endfunction

    // Reference model: q holds every accepted, not yet popped transaction in
    // order; the first m_b of them are in the output buffer, any remaining
    // one is in the execute stage.
    ent_t             q[$];
    int               m_b = 0;
    logic             m_sc = 1'b0;
    logic             m_so = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic [TAG_W-1:0] dut_tags[$];

    initial begin : compare
        bit   e_occ, m_pop, m_push, exp_rdy, m_load, clr;
        ent_t nent;
        forever begin
            @(negedge clk);
            m_load = 1'b0; m_pop = 1'b0; m_push = 1'b0; clr = 1'b0;
            if (!rst_n) begin
                q.delete(); m_b = 0; m_sc = 1'b0; m_so = 1'b0; m_cnt = '0;
            end else begin
                e_occ   = (q.size() > m_b);
                m_pop   = (m_b > 0) && out_ready;
                m_push  = e_occ && ((m_b < 2) || m_pop);
                exp_rdy = !e_occ || m_push;
                m_load  = in_valid && exp_rdy;
                clr     = flag_clr;
                chk("out_valid", 64'(out_valid), 64'(m_b > 0));
                chk("in_ready", 64'(in_ready), 64'(exp_rdy));
                chk("sticky_carry", 64'(sticky_carry), 64'(m_sc));
                chk("sticky_ovf", 64'(sticky_ovf), 64'(m_so));
                chk("op_count", 64'(op_count), 64'(m_cnt));
                if (m_b > 0) begin
                    chk("out_result", 64'(out_result), 64'(q[0].r));
                    chk("out_carry", 64'(out_carry), 64'(q[0].c));
                    chk("out_ovf", 64'(out_ovf), 64'(q[0].o));
                    chk("out_zero", 64'(out_zero), 64'(q[0].z));
                    chk("out_illegal", 64'(out_illegal), 64'(q[0].il));
                    chk("out_tag", 64'(out_tag), 64'(q[0].tag));
                    if (m_pop) dut_tags.push_back(out_tag);
                end
                if (e_occ) begin
                    chk("alu_a", 64'(alu_a), 64'(q[m_b].a));
                    chk("alu_b", 64'(alu_b), 64'(q[m_b].b));
                    chk("alu_op", 64'(alu_op), 64'(q[m_b].op));
                end
                nent = mk(in_a, in_b, in_op, in_tag);
            end
            @(posedge clk);
            if (rst_n) begin
                if (m_push) begin
                    m_sc = (m_sc && !clr) || q[m_b].c;
                    m_so = (m_so && !clr) || q[m_b].o;
                    m_b++;
                end else begin
                    m_sc = m_sc && !clr;
                    m_so = m_so && !clr;
                end
                if (m_pop) begin
                    void'(q.pop_front());
                    m_b--;
                    if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
                end
                if (m_load) q.push_back(nent);
            end
        end
    end

    // Offer one transaction; returns after the accepting edge (+1).
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [TAG_W-1:0] tag, output int stalls);
        bit rdy;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
        stalls = 0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            stalls++;
            if (stalls > 200) begin
                chk("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_op = 4'($urandom); in_tag = TAG_W'($urandom);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk(name, 64'(out_valid), 64'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        ent_t e;
        int   st;
        int   tot;
        logic [CNT_W-1:0] c0;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
        out_ready = 1'b0; flag_clr = 1'b0;

        // Pin the reference model with hand-computed values
        e = mk(32'hFFFF_FFFF, 32'd1, 4'd0, 4'd3);
        chk("ref_add_r", 64'(e.r), 64'd0);
        chk("ref_add_c", 64'(e.c), 64'd1);
        chk("ref_add_z", 64'(e.z), 64'd1);
        e = mk(32'h8000_0000, 32'd1, 4'd1, 4'd0);
        chk("ref_sub_r", 64'(e.r), 64'h7FFF_FFFF);
        chk("ref_sub_o", 64'(e.o), 64'd1);
        e = mk(32'd5, 32'd7, 4'hC, 4'd0);
        chk("ref_ill", 64'({e.r == 32'd0, e.z, e.c, e.o, e.il}), 64'b11001);

        // Reset state
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_fields", 64'({out_result, out_carry, out_ovf, out_zero, out_illegal, out_tag}), 64'd0);
        chk("rst_alu", 64'({alu_a, alu_op}), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        chk("rst_sticky", 64'({sticky_carry, sticky_ovf}), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single add with latency check
        send(32'hFFFF_FFFF, 32'd1, 4'd0, 4'd3, st);
        @(negedge clk);
        chk("add_not_yet_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_result", 64'(out_result), 64'd0);
        chk("add_flags", 64'({out_carry, out_zero, out_ovf}), 64'b110);
        chk("add_tag", 64'(out_tag), 64'd3);
        @(posedge clk); #1 out_ready = 1'b1;
        cycles(1);
        chk("add_op_count", 64'(op_count), 64'd1);

        // Sticky overflow, persistence, clear, and set-beats-clear
        send(32'h8000_0000, 32'd1, 4'd1, 4'd1, st);
        cycles(2);
        chk("sticky_set", 64'(sticky_ovf), 64'd1);
        send(32'd0, 32'd0, 4'd2, 4'd2, st);
        cycles(2);
        chk("sticky_hold", 64'(sticky_ovf), 64'd1);
        flag_clr = 1'b1; cycles(1); flag_clr = 1'b0;
        chk("sticky_clear", 64'(sticky_ovf), 64'd0);
        send(32'h8000_0000, 32'd1, 4'd1, 4'd4, st);
        flag_clr = 1'b1; cycles(1); flag_clr = 1'b0;
        chk("sticky_set_wins", 64'(sticky_ovf), 64'd1);
        cycles(3);

        // Back-pressure: three held, fourth accepted when out_ready rises
        out_ready = 1'b0;
        dut_tags.delete();
        tot = 0;
        for (int i = 0; i < 3; i++) begin
            send($urandom, $urandom, 4'd4, TAG_W'(i), st);
            tot += st;
        end
        chk("bp_no_stall_first3", 64'(tot), 64'd0);
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_op = 4'd4; in_tag = 4'd3;
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_rise", 64'(in_ready), 64'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        cycles(6);
        chk("bp_pop_count", 64'(dut_tags.size()), 64'd4);
        for (int i = 0; i < 4 && i < dut_tags.size(); i++)
            chk("bp_tag_order", 64'(dut_tags[i]), 64'(i));

        // Illegal opcode
        out_ready = 1'b0;
        send(32'd5, 32'd7, 4'hC, 4'd9, st);
        wait_out_valid("ill_valid");
        chk("ill_result", 64'(out_result), 64'd0);
        chk("ill_flags", 64'({out_zero, out_carry, out_ovf, out_illegal}), 64'b1001);
        chk("ill_tag", 64'(out_tag), 64'd9);
        @(posedge clk); #1 out_ready = 1'b1;
        cycles(3);

        // Streaming: 100 random legal ops at full rate
        c0 = op_count;
        tot = 0;
        for (int i = 0; i < 100; i++) begin
            send($urandom, $urandom, 4'($urandom_range(0, 8)), TAG_W'(i), st);
            tot += st;
        end
        chk("stream_stalls", 64'(tot), 64'd0);
        cycles(4);
        chk("stream_op_count", 64'(op_count), 64'(c0 + CNT_W'(100)));

        // Random traffic with random back-pressure, clears and opcodes
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            in_b      = $urandom;
            in_op     = 4'($urandom);
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flag_clr  = ($urandom_range(0, 7) == 0);
            cycles(1);
        end
        in_valid = 1'b0; flag_clr = 1'b0; out_ready = 1'b1;
        cycles(5);

        // Reset with two buffered entries and E occupied
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 4'd0, TAG_W'(i + 5), st);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_op_count", 64'(op_count), 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(32'd10, 32'd20, 4'd0, 4'd7, st);
        wait_out_valid("post_rst_valid");
        chk("post_rst_result", 64'(out_result), 64'd30);
        chk("post_rst_tag", 64'(out_tag), 64'd7);
        cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
